// File: rtl/kb_cmd_pkg.sv
// Shared constants for the keyboard command scheduler: PS/2 scan codes,
// the 3-bit command encoding issued to the game engine, and the
// decoder state encoding.
package kb_cmd_pkg;

  // PS/2 set-2 scan codes for the tracked keys and the prefix bytes
  localparam logic [7:0] SPACE    = 8'h29;
  localparam logic [7:0] KEY_P    = 8'h4D;
  localparam logic [7:0] EXT      = 8'hE0;
  localparam logic [7:0] BRK      = 8'hF0;
  localparam logic [7:0] LEFT_SC  = 8'h6B;
  localparam logic [7:0] RIGHT_SC = 8'h74;

  // Command codes presented on cmd_code
  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_DROP    = 3'd1;
  localparam logic [2:0] CMD_LEFT    = 3'd2;
  localparam logic [2:0] CMD_RIGHT   = 3'd3;
  localparam logic [2:0] CMD_PAUSE   = 3'd4;
  localparam logic [2:0] CMD_GRAVITY = 3'd5;

  // Scan-code decoder states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // One-hot key_down bit for a key command (bit = code - 1); zero for
  // anything that is not a held key.
  function automatic logic [3:0] key_mask(input logic [2:0] code);
    case (code)
      CMD_DROP:  key_mask = 4'b0001;
      CMD_LEFT:  key_mask = 4'b0010;
      CMD_RIGHT: key_mask = 4'b0100;
      CMD_PAUSE: key_mask = 4'b1000;
      default:   key_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous DEPTH x 3 command FIFO with first-word fall-through read
// (dout shows the head whenever empty is low). A push while full is
// accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the array has no reset; entries are only read after being written,
  // and leaving reset off lets it map onto plain storage cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kb_cmd_scheduler.sv
// Keyboard command scheduler: decodes PS/2 make/break sequences for the
// four game keys into one-shot commands, queues them, merges in gravity
// ticks and issues one command at a time over cmd_valid/cmd_ready.
// Owns the pause state and suppresses typematic repeats.
// Optional: define DROP_COUNT_EN to add the 4-bit drop_count output.
module kb_cmd_scheduler
  import kb_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tick_gravity,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       paused,
  output logic       overflow
`ifdef DROP_COUNT_EN
  ,
  output logic [3:0] drop_count
`endif
);

  dec_state_t state, state_next;
  logic [3:0] key_down;
  logic [2:0] make_code;
  logic [3:0] make_mask;
  logic [3:0] clr_mask;
  logic       make_push;

  logic       grav_pend;
  logic       hs;
  logic       pause_next;
  logic       load_en;
  logic       discard;
  logic       load_fifo;
  logic       load_grav;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_head;

  // Decoder next state, make events and break clears.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    make_code  = CMD_NONE;
    clr_mask   = '0;
    if (rx_done_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == EXT)        state_next = ST_EXT;
          else if (rx_data == BRK)   state_next = ST_BRK;
          else if (rx_data == SPACE) make_code  = CMD_DROP;
          else if (rx_data == KEY_P) make_code  = CMD_PAUSE;
        end
        ST_EXT: begin
          state_next = ST_IDLE;
          if (rx_data == BRK)           state_next = ST_EXT_BRK;
          else if (rx_data == LEFT_SC)  make_code  = CMD_LEFT;
          else if (rx_data == RIGHT_SC) make_code  = CMD_RIGHT;
        end
        ST_BRK: begin
          state_next = ST_IDLE;
          if (rx_data == SPACE)      clr_mask = key_mask(CMD_DROP);
          else if (rx_data == KEY_P) clr_mask = key_mask(CMD_PAUSE);
        end
        ST_EXT_BRK: begin
          state_next = ST_IDLE;
          if (rx_data == LEFT_SC)       clr_mask = key_mask(CMD_LEFT);
          else if (rx_data == RIGHT_SC) clr_mask = key_mask(CMD_RIGHT);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A make only produces a command when the key was not already held.
  assign make_mask = key_mask(make_code);
  assign make_push = |(make_mask & ~key_down);

  // Handshake and arbitration. pause_next is the pause state after this
  // edge, so a head arriving as PAUSE completes is already filtered.
  assign hs         = cmd_valid && cmd_ready;
  assign pause_next = paused ^ (hs && (cmd_code == CMD_PAUSE));
  assign load_en    = !cmd_valid || cmd_ready;
  assign discard    = pause_next && !fifo_empty && (fifo_head != CMD_PAUSE);
  assign load_fifo  = load_en && !fifo_empty && !discard;
  assign load_grav  = load_en && fifo_empty && grav_pend && !pause_next;
  assign fifo_pop   = discard || load_fifo;
  assign fifo_push  = make_push && (!fifo_full || fifo_pop);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (make_code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Decoder state and held-key tracking.
  // NOTE: sequential state is updated with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      key_down <= '0;
    end else begin
      state    <= state_next;
      key_down <= (key_down | make_mask) & ~clr_mask;
    end
  end

  // Sticky overflow: a new key event found the FIFO full with no pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     overflow <= 1'b0;
    else if (make_push && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  // Gravity latch: coalesces ticks, cleared while paused; a tick in the
  // same cycle as a gravity load keeps it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             grav_pend <= 1'b0;
    else if (pause_next)   grav_pend <= 1'b0;
    else if (tick_gravity) grav_pend <= 1'b1;
    else if (load_grav)    grav_pend <= 1'b0;
  end

  // Output slot: loads when empty or on handshake, FIFO head first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
    end else if (load_en) begin
      if (load_fifo) begin
        cmd_valid <= 1'b1;
        cmd_code  <= fifo_head;
      end else if (load_grav) begin
        cmd_valid <= 1'b1;
        cmd_code  <= CMD_GRAVITY;
      end else begin
        cmd_valid <= 1'b0;
        cmd_code  <= CMD_NONE;
      end
    end
  end

  // Pause flag toggles when a PAUSE command is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) paused <= 1'b0;
    else       paused <= pause_next;
  end

`ifdef DROP_COUNT_EN
  // Count accepted DROP commands, wrapping at 16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             drop_count <= '0;
    else if (hs && (cmd_code == CMD_DROP)) drop_count <= drop_count + 4'd1;
  end
`endif

endmodule
